mips_cpu_hilo_muldiv: RTL

//  Multi-cycle multiply/divide unit with the architectural HI/LO registers. Sits beside the ALU and

---
 rtl/mips_cpu_alu_pkg.sv | 21 ++
 rtl/mips_cpu_muldiv_core.sv | 71 +++++++
 rtl/mips_cpu_hilo_muldiv.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_cpu_alu_pkg.sv
// Shared ALU decoder codes and the mul/div sequencing states.
// Pure declarations; no timing or flow-control content.
package mips_cpu_alu_pkg;

    localparam logic [4:0] ALU_MULTU = 5'b00111;
    localparam logic [4:0] ALU_MULT  = 5'b01000;
    localparam logic [4:0] ALU_DIV   = 5'b01111;
    localparam logic [4:0] ALU_DIVU  = 5'b10000;
    localparam logic [4:0] ALU_MTHI  = 5'b10001;
    localparam logic [4:0] ALU_MTLO  = 5'b10010;
    localparam logic [4:0] ALU_MFHI  = 5'b11010;
    localparam logic [4:0] ALU_MFLO  = 5'b11011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide, one bit per edge.
// ITER edges after start; done is high during the last iteration cycle; start is honoured only when the owner is idle.
module mips_cpu_muldiv_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(ITER);

    logic [CW-1:0]    count;
    logic             run;
    logic             mode_div;
    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] pl;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    // ph/pl double as {partial product, multiplier} or {remainder, dividend->quotient}
    always_comb begin
        sum     = {1'b0, ph} + (pl[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {ph, pl[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd});
        diff    = shifted - {1'b0, opnd};
    end

    assign done   = run && (count == CW'(ITER-1));
    assign result = {ph, pl};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            run      <= 1'b0;
            mode_div <= 1'b0;
            ph       <= '0;
            pl       <= '0;
            opnd     <= '0;
        end else if (start) begin
            count    <= '0;
            run      <= 1'b1;
            mode_div <= div;
            ph       <= '0;
            pl       <= div ? a : b;
            opnd     <= div ? b : a;
        end else if (run) begin
            if (mode_div) begin
                ph <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                pl <= {pl[WIDTH-2:0], ge};
            end else begin
                ph <= sum[WIDTH:1];
                pl <= {sum[0], pl[WIDTH-1:1]};
            end
            count <= count + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO registers with a multi-cycle MULT/MULTU/DIV/DIVU unit; MTHI/MTLO take one edge.
// Mul/div: busy for 33 cycles after issue; inputs are ignored while busy (controller stalls).
module mips_cpu_hilo_muldiv
    import mips_cpu_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mfresult
);

    muldiv_state_t      state;
    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic               start;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               neg_q;
    logic               neg_r;
    logic               divzero;
    logic               is_div;
    logic [WIDTH-1:0]   dividend;
    logic               core_done;
    logic [2*WIDTH-1:0] core_result;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        case (alucontrol)
            ALU_MULTU: op_mul = 1'b1;
            ALU_MULT:  begin op_mul = 1'b1; op_signed = 1'b1; end
            ALU_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
            ALU_DIVU:  op_div = 1'b1;
            default:   ;
        endcase
    end

    assign busy  = (state != IDLE);
    assign start = (state == IDLE) && en && (op_mul || op_div);
    assign a_abs = (op_signed && srca[WIDTH-1]) ? -srca : srca;
    assign b_abs = (op_signed && srcb[WIDTH-1]) ? -srcb : srcb;

    mips_cpu_muldiv_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .div    (op_div),
        .a      (a_abs),
        .b      (b_abs),
        .done   (core_done),
        .result (core_result)
    );

    // Core works on magnitudes; signs are restored here in FIX
    always_comb begin
        prod = neg_q ? -core_result : core_result;
        quo  = neg_q ? -core_result[WIDTH-1:0] : core_result[WIDTH-1:0];
        rem  = neg_r ? -core_result[2*WIDTH-1:WIDTH] : core_result[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        case (alucontrol)
            ALU_MFHI: mfresult = hi;
            ALU_MFLO: mfresult = lo;
            default:  mfresult = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            divzero  <= 1'b0;
            is_div   <= 1'b0;
            dividend <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= op_div ? DIV : MUL;
                        neg_q    <= op_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r    <= op_signed && srca[WIDTH-1];
                        divzero  <= op_div && (srcb == '0);
                        is_div   <= op_div;
                        dividend <= srca;
                    end else if (en && alucontrol == ALU_MTHI) begin
                        hi <= srca;
                    end else if (en && alucontrol == ALU_MTLO) begin
                        lo <= srca;
                    end
                end
                MUL, DIV: begin
                    if (core_done) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!is_div) begin
                        {hi, lo} <= prod;
                    end else if (divzero) begin
                        hi <= dividend;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
